// File: rtl/vga_pkg.sv
// Shared definitions for the VGA output path.
// Holds the 640x480@72Hz timing defaults (with the derived line and frame
// totals), counter and colour widths, and the 3-bit colour codes ({R,G,B}).
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 24;
    localparam int VGA_H_SYNC   = 40;
    localparam int VGA_H_BP     = 128;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 9;
    localparam int VGA_V_SYNC   = 3;
    localparam int VGA_V_BP     = 28;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Asserted level of hsync/vsync; 0 means active-low pulses.
    localparam bit VGA_SYNC_POL = 1'b0;

    localparam int CNT_W   = 10;
    localparam int COLOR_W = 3;

    typedef enum logic [COLOR_W-1:0] {
        COLOR_BLACK   = 3'b000,
        COLOR_BLUE    = 3'b001,
        COLOR_GREEN   = 3'b010,
        COLOR_CYAN    = 3'b011,
        COLOR_RED     = 3'b100,
        COLOR_MAGENTA = 3'b101,
        COLOR_YELLOW  = 3'b110,
        COLOR_WHITE   = 3'b111
    } color_e;

endpackage

// File: rtl/vga_if.sv
// Bundle between the VGA timing/output stage and its pixel-side partners.
// master: the timing generator (drives coordinates and monitor pins,
//         receives the pixel strobe and the returned colour).
// slave : the environment (drives px_en and color_px, observes the rest).
interface vga_if;
    import vga_pkg::*;

    logic               px_en;
    logic [CNT_W-1:0]   x_px;
    logic [CNT_W-1:0]   y_px;
    logic               activevideo;
    logic [COLOR_W-1:0] color_px;
    logic [COLOR_W-1:0] rgb;
    logic               hsync;
    logic               vsync;
    logic               frame_start;

    modport master (
        input  px_en, color_px,
        output x_px, y_px, activevideo, rgb, hsync, vsync, frame_start
    );

    modport slave (
        output px_en, color_px,
        input  x_px, y_px, activevideo, rgb, hsync, vsync, frame_start
    );
endinterface

// File: rtl/vga_counter.sv
// Wrapping counter for one VGA axis.
// Ports: clk, srst (sync, active-high), en (advance one step),
//        count (current value, 0..TOTAL-1), wrap (count is at TOTAL-1, i.e.
//        the next enabled edge returns to 0), in_sync (count lies inside the
//        sync pulse window [SYNC_START, SYNC_START+SYNC_LEN-1]).
module vga_counter #(
    parameter int W          = 10,
    parameter int TOTAL      = 832,
    parameter int SYNC_START = 664,
    parameter int SYNC_LEN   = 40
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         in_sync
);
    localparam logic [W-1:0] LAST_C       = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_FIRST_C = W'(SYNC_START);
    localparam logic [W-1:0] SYNC_LAST_C  = W'(SYNC_START + SYNC_LEN - 1);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    assign wrap = (count_reg == LAST_C);

    always_comb begin
        count_next = count_reg;
        if (en) begin
            count_next = wrap ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count   = count_reg;
    assign in_sync = (count_reg >= SYNC_FIRST_C) && (count_reg <= SYNC_LAST_C);
endmodule

// File: rtl/vga_sync.sv
// VGA timing generator and registered output stage.
// Ports: clk, reset (sync, active-high), bus (vga_if.master):
//   px_en in        pixel strobe, every register advances only when high
//   x_px/y_px out   current column/line counters
//   activevideo out combinational visible-area flag
//   color_px in     colour returned for (x_px, y_px)
//   rgb/hsync/vsync/frame_start out  registered pins, one strobe behind x/y
module vga_sync
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = VGA_SYNC_POL
) (
    input  logic  clk,
    input  logic  reset,
    vga_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);

    logic [CNT_W-1:0]   h_cnt;
    logic [CNT_W-1:0]   v_cnt;
    logic               h_wrap;
    logic               v_wrap_unused;
    logic               h_in_sync;
    logic               v_in_sync;
    logic               activevideo;

    logic [COLOR_W-1:0] rgb_reg, rgb_next;
    logic               hsync_reg, hsync_next;
    logic               vsync_reg, vsync_next;
    logic               frame_start_reg, frame_start_next;

    vga_counter #(
        .W          (CNT_W),
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_LEN   (H_SYNC)
    ) u_h_counter (
        .clk     (clk),
        .srst    (reset),
        .en      (bus.px_en),
        .count   (h_cnt),
        .wrap    (h_wrap),
        .in_sync (h_in_sync)
    );

    // The line counter only moves on the last pixel of a line, so vsync can
    // only change on the same edge as a line wrap.
    vga_counter #(
        .W          (CNT_W),
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_LEN   (V_SYNC)
    ) u_v_counter (
        .clk     (clk),
        .srst    (reset),
        .en      (bus.px_en & h_wrap),
        .count   (v_cnt),
        .wrap    (v_wrap_unused),
        .in_sync (v_in_sync)
    );

    assign activevideo = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);

    // Blanking: colour from the generator is masked outside the visible area,
    // so whatever it returns during blanking never reaches the pins.
    genvar gi;
    generate
        for (gi = 0; gi < COLOR_W; gi++) begin : g_blank
            assign rgb_next[gi] = bus.color_px[gi] & activevideo;
        end
    endgenerate

    assign hsync_next       = h_in_sync ? SYNC_POL : ~SYNC_POL;
    assign vsync_next       = v_in_sync ? SYNC_POL : ~SYNC_POL;
    assign frame_start_next = (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_reg         <= COLOR_BLACK;
            hsync_reg       <= ~SYNC_POL;
            vsync_reg       <= ~SYNC_POL;
            frame_start_reg <= 1'b0;
        end else if (bus.px_en) begin
            rgb_reg         <= rgb_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign bus.x_px        = h_cnt;
    assign bus.y_px        = v_cnt;
    assign bus.activevideo = activevideo;
    assign bus.rgb         = rgb_reg;
    assign bus.hsync       = hsync_reg;
    assign bus.vsync       = vsync_reg;
    assign bus.frame_start = frame_start_reg;
endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync.
// Two instances share clk/reset/px_en/color_px: one with the 640x480@72
// defaults and one with a tiny timing set and active-high syncs, so whole
// frames and vsync pulses fit in a short run. The reference model tracks only
// the number of strobes since reset and derives every expected pin value from
// the timing rules with plain arithmetic.
module tb_vga_sync;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic px_en;
    logic [2:0] color;

    always #5 clk = ~clk;

    vga_if bus_f ();
    vga_if bus_s ();

    assign bus_f.px_en    = px_en;
    assign bus_f.color_px = color;
    assign bus_s.px_en    = px_en;
    assign bus_s.color_px = color;

    vga_sync dut_f (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_f.master)
    );

    vga_sync #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (4),
        .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
        .SYNC_POL (1'b1)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.master)
    );

    // Timing per instance: index 0 = defaults, 1 = small.
    int ha [2], hfp [2], hsw [2], hbp [2];
    int va [2], vfp [2], vsw [2], vbp [2];
    bit pol [2];

    // Model state: strobes since frame origin, plus expected pin registers.
    int         n_m   [2];
    logic [2:0] m_rgb [2];
    bit         m_hs  [2];
    bit         m_vs  [2];
    bit         m_fs  [2];
    bit         valid [2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int h_total(input int k);
        return ha[k] + hfp[k] + hsw[k] + hbp[k];
    endfunction

    function automatic int v_total(input int k);
        return va[k] + vfp[k] + vsw[k] + vbp[k];
    endfunction

    task automatic model_step(input int k, input bit rst, input bit en, input logic [2:0] col);
        int ht, vt, x, y;
        ht = h_total(k);
        vt = v_total(k);
        if (rst) begin
            n_m[k]   = 0;
            m_rgb[k] = 3'b000;
            m_hs[k]  = ~pol[k];
            m_vs[k]  = ~pol[k];
            m_fs[k]  = 1'b0;
            valid[k] = 1'b1;
        end else if (en && valid[k]) begin
            x = n_m[k] % ht;
            y = n_m[k] / ht;
            m_rgb[k] = (x < ha[k] && y < va[k]) ? col : 3'b000;
            m_hs[k]  = (x >= ha[k] + hfp[k] && x < ha[k] + hfp[k] + hsw[k]) ? pol[k] : ~pol[k];
            m_vs[k]  = (y >= va[k] + vfp[k] && y < va[k] + vfp[k] + vsw[k]) ? pol[k] : ~pol[k];
            m_fs[k]  = (n_m[k] == 0);
            n_m[k]   = (n_m[k] + 1) % (ht * vt);
        end
    endtask

    task automatic compare_one(input int k, input int x, input int y, input int av,
                               input int rgb, input int hs, input int vs, input int fs);
        string nm;
        int ex, ey;
        nm = (k == 0) ? "full" : "small";
        ex = n_m[k] % h_total(k);
        ey = n_m[k] / h_total(k);
        check_eq({nm, ".x_px"}, x, ex);
        check_eq({nm, ".y_px"}, y, ey);
        check_eq({nm, ".activevideo"}, av, int'(ex < ha[k] && ey < va[k]));
        check_eq({nm, ".rgb"}, rgb, int'(m_rgb[k]));
        check_eq({nm, ".hsync"}, hs, int'(m_hs[k]));
        check_eq({nm, ".vsync"}, vs, int'(m_vs[k]));
        check_eq({nm, ".frame_start"}, fs, int'(m_fs[k]));
    endtask

    // Apply inputs for the next edge, advance the model, then sample on the
    // falling edge.
    task automatic cycle(input bit rst, input bit en, input logic [2:0] col);
        reset = rst;
        px_en = en;
        color = col;
        model_step(0, rst, en, col);
        model_step(1, rst, en, col);
        @(negedge clk);
        if (valid[0])
            compare_one(0, int'(bus_f.x_px), int'(bus_f.y_px), int'(bus_f.activevideo),
                        int'(bus_f.rgb), int'(bus_f.hsync), int'(bus_f.vsync),
                        int'(bus_f.frame_start));
        if (valid[1])
            compare_one(1, int'(bus_s.x_px), int'(bus_s.y_px), int'(bus_s.activevideo),
                        int'(bus_s.rgb), int'(bus_s.hsync), int'(bus_s.vsync),
                        int'(bus_s.frame_start));
    endtask

    initial begin
        int waited;
        ha[0] = VGA_H_ACTIVE; hfp[0] = VGA_H_FP; hsw[0] = VGA_H_SYNC; hbp[0] = VGA_H_BP;
        va[0] = VGA_V_ACTIVE; vfp[0] = VGA_V_FP; vsw[0] = VGA_V_SYNC; vbp[0] = VGA_V_BP;
        pol[0] = 1'b0;
        ha[1] = 16; hfp[1] = 2; hsw[1] = 3; hbp[1] = 4;
        va[1] = 8;  vfp[1] = 2; vsw[1] = 2; vbp[1] = 3;
        pol[1] = 1'b1;
        valid[0] = 1'b0;
        valid[1] = 1'b0;

        // Reset held three cycles with px_en high, then free-running.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 3'b101);

        // Constant magenta for two full default lines (blanking exercised).
        for (int i = 0; i < 2 * 832 + 8; i++) cycle(1'b0, 1'b1, 3'b101);

        // px_en alternating: outputs must hold on the idle cycles.
        for (int i = 0; i < 2 * 832 + 4; i++) cycle(1'b0, (i % 2) == 0, 3'($urandom));

        // Random strobes, colours and the occasional reset.
        for (int i = 0; i < 6000; i++)
            cycle($urandom_range(0, 1999) == 0, $urandom_range(0, 3) != 0, 3'($urandom));

        // Reset mid-line at x_px=300 while px_en is low.
        waited = 0;
        while (int'(bus_f.x_px) != 300 && waited < 2000) begin
            cycle(1'b0, 1'b1, 3'($urandom));
            waited++;
        end
        check_eq("wait_x300_reached", int'(bus_f.x_px), 300);
        cycle(1'b1, 1'b0, 3'($urandom));
        for (int i = 0; i < 1000; i++) cycle(1'b0, 1'b1, 3'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- Timing generator and output stage for the 640x480@72Hz, 3-bit-colour VGA path.
- Produces the pixel coordinates (x_px, y_px) consumed by the colour-bar generator.
- Takes that generator's colour back and drives the monitor pins: blanked rgb, hsync and vsync, all registered and mutually aligned.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 40, hsync pulse width (pixels)
H_BP, 128, horizontal back porch (pixels); line total 832
V_ACTIVE, 480, visible lines per frame
V_FP, 9, vertical front porch (lines)
V_SYNC, 3, vsync pulse width (lines)
V_BP, 28, vertical back porch (lines); frame total 520
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
px_en  in  1  pixel strobe; all state advances only on clk edges with px_en=1 (tie high when clk is the 31.5 MHz pixel clock)
x_px  out  10  current column counter, 0..831
y_px  out  10  current line counter, 0..519
activevideo  out  1  1 when x_px<H_ACTIVE and y_px<V_ACTIVE
color_px  in  3  colour for (x_px, y_px), combinational return from downstream generator
rgb  out  3  registered, blanked colour to DAC pins
hsync  out  1  registered horizontal sync
vsync  out  1  registered vertical sync
frame_start  out  1  registered one-strobe pulse marking pixel (0,0) on the pins

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset (sampled on clk, regardless of px_en):
  - h_cnt=0, v_cnt=0
  - rgb=0, hsync=vsync=~SYNC_POL, frame_start=0
- Counters:
  - Registered h_cnt/v_cnt, 10 bits each; they drive x_px/y_px directly.
  - activevideo is combinational from the counters.
- On px_en=1:
  - h_cnt increments.
  - At h_cnt=H_TOTAL-1 (831), h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt=V_TOTAL-1 (519), v_cnt wraps to 0 on the same edge.
  - H_TOTAL and V_TOTAL are sums of the respective parameters.
- On px_en=0: all registers hold, including the output stage.
- Output stage, one register level, updated on px_en=1 from the pre-edge counter values:
  - rgb <= activevideo ? color_px : 3'b000
  - hsync <= SYNC_POL when h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [664,703], else ~SYNC_POL
  - vsync <= SYNC_POL when v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [489,491], else ~SYNC_POL
  - frame_start <= (h_cnt==0 && v_cnt==0)
- Latency:
  - rgb, hsync, vsync and frame_start lag x_px/y_px by exactly one px_en strobe.
  - They are mutually aligned with each other.
- color_px is sampled only when activevideo=1; its value during blanking is don't-care and never reaches rgb.
- vsync changes only on the same edge as a line wrap; no mid-line vsync edges.
- Reset mid-frame: the next edge restarts at (0,0) and outputs go inactive; the partial frame is abandoned with no glitch beyond that.
- Reset while px_en=0 still takes effect.
- The counters never exceed H_TOTAL-1 / V_TOTAL-1.

Decomposition:
- Shared package vga_pkg:
  - 640x480@72 timing constants (the parameter defaults plus H_TOTAL/V_TOTAL)
  - colour width constant (3)
  - colour codes
- Natural sub-module vga_counter: one instance per axis. It is a parameterised wrapping counter with enable, carry-out (wrap) and in-sync-window flag.
  - Horizontal instance: enable = px_en.
  - Vertical instance: enable = px_en & horizontal wrap.

Test Plan:
- Reset held 3 cycles, px_en=1, then released:
  - x_px=0, y_px=0, activevideo=1
  - rgb=0, hsync=1, vsync=1, frame_start=0
  - One strobe later: frame_start=1 for exactly one strobe.
- Drive color_px=3'b101 constant:
  - rgb=101 for 640 strobes per line.
  - rgb=000 when rgb-stage input had x_px in 640..831 or y_px in 480..519.
- Count strobes from line start:
  - hsync falls one strobe after x_px=664 and rises one strobe after x_px=704.
  - 40-strobe low pulse; 832-strobe period.
- Run full frame:
  - vsync low for exactly 3 lines, starting at the edge after the v_cnt=488→489 transition.
  - frame period = 832*520 = 432640 strobes.
- px_en toggled 1/0 alternately: all outputs hold during px_en=0; line period = 1664 clk.
- Assert reset at x_px=300, y_px=200 for 1 cycle: next cycle x_px=0, y_px=0, rgb=0, syncs inactive; counting resumes normally.
